// File: rtl/cotm32_pipeline_pkg.sv
// Shared types for the cotm32 pipeline control path.
// Next-PC source select and stall/flush sequencer states.
package cotm32_pipeline_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_TRAP   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    MDU_WAIT  = 2'd2,
    TRAP_PEND = 2'd3
  } pipe_ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: ID sources against EX load destination.
// x0 is never a real dependency.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic              i_ex_valid,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_ex_rd,
  output logic              o_hazard
);

  logic w_hit1;
  logic w_hit2;
  logic w_rd_nz;

  assign w_hit1  = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_hit2  = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign w_rd_nz = |i_ex_rd;

  assign o_hazard = i_ex_valid & i_ex_is_load & w_rd_nz
                  & (w_hit1 | w_hit2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Handles load-use, redirects, memory/MDU waits and trap entry.
module pipeline_ctrl
  import cotm32_pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic              i_ex_valid,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_redirect,
  input  logic              i_ex_mdu_start,
  input  logic              i_mdu_done,
  output logic              o_mdu_kill,
  input  logic              i_mem_req,
  input  logic              i_mem_ack,
  input  logic              i_trap_req,
  output logic              o_trap_ack,
  output logic              o_pc_stall,
  output logic              o_ifid_stall,
  output logic              o_ifid_flush,
  output logic              o_idex_stall,
  output logic              o_idex_flush,
  output logic              o_exmem_stall,
  output logic              o_exmem_flush,
  output logic              o_memwb_flush,
  output pc_sel_t           o_pc_sel,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  pipe_ctrl_state_t r_state;
  pipe_ctrl_state_t w_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;
  logic             w_mem_hold;
  logic             w_run_evt;
  logic             w_mem_stall;
  logic             w_mdu_stall;
  logic             w_trap;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_lud (
    .i_id_rs1    (i_id_rs1),
    .i_id_rs2    (i_id_rs2),
    .i_id_use_rs1(i_id_use_rs1),
    .i_id_use_rs2(i_id_use_rs2),
    .i_ex_valid  (i_ex_valid),
    .i_ex_is_load(i_ex_is_load),
    .i_ex_rd     (i_ex_rd),
    .o_hazard    (w_load_use)
  );

  assign w_mem_hold = i_mem_req & ~i_mem_ack;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (o_pc_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;

  // State decode picks one response class; outputs are derived below.
  always_comb begin
    w_next      = r_state;
    w_run_evt   = 1'b0;
    w_mem_stall = 1'b0;
    w_mdu_stall = 1'b0;
    w_trap      = 1'b0;
    o_mdu_kill  = 1'b0;
    if (!i_rst) begin
      case (r_state)
        RUN: begin
          if (i_trap_req) begin
            if (w_mem_hold) begin
              w_mem_stall = 1'b1;
              w_next      = TRAP_PEND;
            end else begin
              w_trap = 1'b1;
              w_next = RUN;
            end
          end else if (w_mem_hold) begin
            w_mem_stall = 1'b1;
            w_next      = MEM_WAIT;
          end else begin
            w_run_evt = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!i_mem_ack) begin
            w_mem_stall = 1'b1;
            w_next = i_trap_req ? TRAP_PEND : MEM_WAIT;
          end else if (i_trap_req) begin
            w_trap = 1'b1;
            w_next = RUN;
          end else begin
            w_run_evt = 1'b1;
            w_next    = RUN;
          end
        end
        MDU_WAIT: begin
          if (i_trap_req) begin
            w_trap     = 1'b1;
            o_mdu_kill = 1'b1;
            w_next     = RUN;
          end else if (i_mdu_done) begin
            w_next = RUN;
          end else begin
            w_mdu_stall = 1'b1;
          end
        end
        TRAP_PEND: begin
          if (i_mem_ack) begin
            w_trap = 1'b1;
            w_next = RUN;
          end else begin
            w_mem_stall = 1'b1;
          end
        end
        default: w_next = RUN;
      endcase
    end
    // The ack cycle of a memory wait advances EX, so it must see redirects.
    if (w_run_evt && i_ex_mdu_start && !i_mdu_done) begin
      w_mdu_stall = 1'b1;
      w_next      = MDU_WAIT;
    end
  end

  logic w_redirect;
  logic w_lu_stall;

  assign w_redirect = w_run_evt & ~w_mdu_stall & i_ex_redirect;
  assign w_lu_stall = w_run_evt & ~w_mdu_stall & ~i_ex_redirect
                    & w_load_use;

  always_comb begin
    o_trap_ack    = w_trap;
    o_pc_stall    = w_mem_stall | w_mdu_stall | w_lu_stall;
    o_ifid_stall  = w_mem_stall | w_mdu_stall | w_lu_stall;
    o_idex_stall  = w_mem_stall | w_mdu_stall;
    o_exmem_stall = w_mem_stall;
    o_ifid_flush  = i_rst | w_trap | w_redirect;
    o_idex_flush  = i_rst | w_trap | w_redirect | w_lu_stall;
    o_exmem_flush = i_rst | w_trap | w_mdu_stall;
    o_memwb_flush = i_rst | w_trap | w_mem_stall;
    o_pc_sel      = PC_SEQ;
    if (w_trap) begin
      o_pc_sel = PC_TRAP;
    end else if (w_redirect) begin
      o_pc_sel = PC_BRANCH;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl.
// Control bits packed as {pcs,ifs,iff,ids,idf,exs,exf,wbf,ack,kill}.
module tb_pipeline_ctrl;
  import cotm32_pipeline_pkg::*;

  localparam logic [9:0] NONE  = 10'b0000000000;
  localparam logic [9:0] RST_V = 10'b0010101100;
  localparam logic [9:0] LU    = 10'b1100100000;
  localparam logic [9:0] BR    = 10'b0010100000;
  localparam logic [9:0] MEMS  = 10'b1101010100;
  localparam logic [9:0] MDUS  = 10'b1101001000;
  localparam logic [9:0] TRAP  = 10'b0010101110;
  localparam logic [9:0] TRAPK = 10'b0010101111;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [4:0]  i_id_rs1, i_id_rs2, i_ex_rd;
  logic        i_id_use_rs1, i_id_use_rs2;
  logic        i_ex_valid, i_ex_is_load, i_ex_redirect;
  logic        i_ex_mdu_start, i_mdu_done;
  logic        i_mem_req, i_mem_ack, i_trap_req;
  logic        o_mdu_kill, o_trap_ack, o_pc_stall;
  logic        o_ifid_stall, o_ifid_flush;
  logic        o_idex_stall, o_idex_flush;
  logic        o_exmem_stall, o_exmem_flush, o_memwb_flush;
  pc_sel_t     o_pc_sel;
  logic [31:0] o_stall_cnt;

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_cnt = '0;

  pipeline_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_ex_valid(i_ex_valid), .i_ex_is_load(i_ex_is_load),
    .i_ex_rd(i_ex_rd), .i_ex_redirect(i_ex_redirect),
    .i_ex_mdu_start(i_ex_mdu_start), .i_mdu_done(i_mdu_done),
    .o_mdu_kill(o_mdu_kill),
    .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack),
    .i_trap_req(i_trap_req), .o_trap_ack(o_trap_ack),
    .o_pc_stall(o_pc_stall),
    .o_ifid_stall(o_ifid_stall), .o_ifid_flush(o_ifid_flush),
    .o_idex_stall(o_idex_stall), .o_idex_flush(o_idex_flush),
    .o_exmem_stall(o_exmem_stall), .o_exmem_flush(o_exmem_flush),
    .o_memwb_flush(o_memwb_flush),
    .o_pc_sel(o_pc_sel), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [9:0] obs();
    return {o_pc_stall, o_ifid_stall, o_ifid_flush,
            o_idex_stall, o_idex_flush, o_exmem_stall,
            o_exmem_flush, o_memwb_flush, o_trap_ack, o_mdu_kill};
  endfunction

  task automatic clr();
    i_id_rs1 = '0; i_id_rs2 = '0; i_ex_rd = '0;
    i_id_use_rs1 = 0; i_id_use_rs2 = 0;
    i_ex_valid = 0; i_ex_is_load = 0; i_ex_redirect = 0;
    i_ex_mdu_start = 0; i_mdu_done = 0;
    i_mem_req = 0; i_mem_ack = 0; i_trap_req = 0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    clr();
    #2;
    vecs++;
    if (obs() !== RST_V) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want %b", obs(), RST_V);
    end
    vecs++;
    if (o_pc_sel !== PC_SEQ || o_stall_cnt !== 32'd0) begin
      errs++;
      $display("FAIL reset_sel_cnt: got %0d/%0d want 0/0",
               o_pc_sel, o_stall_cnt);
    end
    step();
    i_rst = 0;
    #1;
    vecs++;
    if (obs() !== NONE) begin
      errs++;
      $display("FAIL post_reset_idle: got %b want %b", obs(), NONE);
    end
  endtask

  task automatic test_load_use();
    step();
    i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd5;
    i_id_rs2 = 5'd5; i_id_use_rs2 = 1; i_id_rs1 = 5'd3;
    #1;
    vecs++;
    if (obs() !== LU || o_pc_sel !== PC_SEQ) begin
      errs++;
      $display("FAIL load_use: got %b/%0d want %b/0", obs(), o_pc_sel, LU);
    end
    step();
    exp_cnt += 1;
    i_ex_valid = 0;
    #1;
    vecs++;
    if (obs() !== NONE || o_stall_cnt !== exp_cnt) begin
      errs++;
      $display("FAIL load_use_bubble: got %b cnt %0d want %b cnt %0d",
               obs(), o_stall_cnt, NONE, exp_cnt);
    end
    step();
    clr();
    i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd0;
    i_id_rs1 = 5'd0; i_id_use_rs1 = 1;
    #1;
    vecs++;
    if (obs() !== NONE) begin
      errs++;
      $display("FAIL load_use_x0: got %b want %b", obs(), NONE);
    end
    step();
    clr();
  endtask

  task automatic test_mem_wait();
    i_mem_req = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++;
      if (obs() !== MEMS) begin
        errs++;
        $display("FAIL mem_wait_%0d: got %b want %b", k, obs(), MEMS);
      end
      step();
    end
    exp_cnt += 3;
    i_mem_ack = 1;
    #1;
    vecs++;
    if (obs() !== NONE || o_stall_cnt !== exp_cnt) begin
      errs++;
      $display("FAIL mem_release: got %b cnt %0d want %b cnt %0d",
               obs(), o_stall_cnt, NONE, exp_cnt);
    end
    step();
    #1;
    vecs++;
    if (obs() !== NONE) begin
      errs++;
      $display("FAIL mem_same_ack: got %b want %b", obs(), NONE);
    end
    step();
    clr();
    #1;
    vecs++;
    if (o_stall_cnt !== exp_cnt) begin
      errs++;
      $display("FAIL mem_cnt: got %0d want %0d", o_stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_mdu();
    step();
    i_ex_mdu_start = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vecs++;
      if (obs() !== MDUS) begin
        errs++;
        $display("FAIL mdu_wait_%0d: got %b want %b", k, obs(), MDUS);
      end
      step();
    end
    exp_cnt += 4;
    i_mdu_done = 1;
    #1;
    vecs++;
    if (obs() !== NONE || o_stall_cnt !== exp_cnt) begin
      errs++;
      $display("FAIL mdu_release: got %b cnt %0d want %b cnt %0d",
               obs(), o_stall_cnt, NONE, exp_cnt);
    end
    step();
    #1;
    vecs++;
    if (obs() !== NONE) begin
      errs++;
      $display("FAIL mdu_same_done: got %b want %b", obs(), NONE);
    end
    step();
    i_mdu_done = 0;
    #1;
    vecs++;
    if (obs() !== MDUS) begin
      errs++;
      $display("FAIL mdu_start2: got %b want %b", obs(), MDUS);
    end
    step();
    step();
    i_trap_req = 1;
    #1;
    vecs++;
    if (obs() !== TRAPK || o_pc_sel !== PC_TRAP) begin
      errs++;
      $display("FAIL mdu_trap_kill: got %b/%0d want %b/2",
               obs(), o_pc_sel, TRAPK);
    end
    step();
    exp_cnt += 2;
    clr();
    #1;
    vecs++;
    if (obs() !== NONE || o_stall_cnt !== exp_cnt) begin
      errs++;
      $display("FAIL mdu_kill_pulse: got %b cnt %0d want %b cnt %0d",
               obs(), o_stall_cnt, NONE, exp_cnt);
    end
  endtask

  task automatic test_trap_mem();
    step();
    i_trap_req = 1;
    #1;
    vecs++;
    if (obs() !== TRAP || o_pc_sel !== PC_TRAP) begin
      errs++;
      $display("FAIL trap_run: got %b/%0d want %b/2", obs(), o_pc_sel, TRAP);
    end
    step();
    clr();
    i_mem_req = 1;
    for (int k = 0; k < 4; k++) begin
      i_trap_req = (k == 1);
      #1;
      vecs++;
      if (obs() !== MEMS || o_trap_ack !== 1'b0) begin
        errs++;
        $display("FAIL trap_pend_%0d: got %b want %b", k, obs(), MEMS);
      end
      step();
    end
    exp_cnt += 4;
    i_mem_ack = 1;
    #1;
    vecs++;
    if (obs() !== TRAP || o_pc_sel !== PC_TRAP) begin
      errs++;
      $display("FAIL trap_pend_take: got %b/%0d want %b/2",
               obs(), o_pc_sel, TRAP);
    end
    step();
    clr();
    #1;
    vecs++;
    if (obs() !== NONE || o_pc_sel !== PC_SEQ) begin
      errs++;
      $display("FAIL trap_pend_exit: got %b/%0d want %b/0",
               obs(), o_pc_sel, NONE);
    end
  endtask

  task automatic test_redirect();
    step();
    i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd7;
    i_id_rs1 = 5'd7; i_id_use_rs1 = 1; i_ex_redirect = 1;
    #1;
    vecs++;
    if (obs() !== BR || o_pc_sel !== PC_BRANCH) begin
      errs++;
      $display("FAIL redirect_lu: got %b/%0d want %b/1", obs(), o_pc_sel, BR);
    end
    step();
    clr();
    i_ex_redirect = 1; i_mem_req = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      vecs++;
      if (obs() !== MEMS || o_pc_sel !== PC_SEQ) begin
        errs++;
        $display("FAIL redirect_mem_%0d: got %b/%0d want %b/0",
                 k, obs(), o_pc_sel, MEMS);
      end
      step();
    end
    exp_cnt += 2;
    i_mem_ack = 1;
    #1;
    vecs++;
    if (obs() !== BR || o_pc_sel !== PC_BRANCH) begin
      errs++;
      $display("FAIL redirect_after_ack: got %b/%0d want %b/1",
               obs(), o_pc_sel, BR);
    end
    step();
    clr();
    #1;
    vecs++;
    if (o_stall_cnt !== exp_cnt) begin
      errs++;
      $display("FAIL redirect_cnt: got %0d want %0d", o_stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    step();
    i_ex_mdu_start = 1;
    #1;
    step();
    #1;
    vecs++;
    if (obs() !== MDUS) begin
      errs++;
      $display("FAIL areset_pre: got %b want %b", obs(), MDUS);
    end
    #2;
    i_rst = 1;
    #1;
    exp_cnt = '0;
    vecs++;
    if (obs() !== RST_V || o_stall_cnt !== exp_cnt) begin
      errs++;
      $display("FAIL areset_now: got %b cnt %0d want %b cnt 0",
               obs(), o_stall_cnt, RST_V);
    end
    step();
    i_rst = 0;
    clr();
    i_trap_req = 1;
    #1;
    vecs++;
    if (obs() !== TRAP) begin
      errs++;
      $display("FAIL areset_state_run: got %b want %b", obs(), TRAP);
    end
    step();
    clr();
    #1;
    vecs++;
    if (o_stall_cnt !== exp_cnt) begin
      errs++;
      $display("FAIL areset_cnt: got %0d want %0d", o_stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_mdu();
    test_trap_mem();
    test_redirect();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
